subs_layer_engine: RTL and testbench



---
 rtl/subs_layer_engine.sv | 101 ++++++++++
 tb/tb_subs_layer_engine.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/subs_layer_engine.sv
// Nibble substitution layer: forward/inverse 4-bit S-box applied
// LANES nibbles per cycle over WIDTH/(4*LANES) passes.
module subs_layer_engine #(
  parameter int WIDTH = 64,
  parameter int LANES = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mode,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  localparam int LN = (LANES < 1) ? 1 : LANES;
  localparam int P  = WIDTH / (4 * LN);
  localparam int CW = $clog2(P + 1);
  localparam logic [CW-1:0] LAST = CW'(P - 1);

  // Entry i of each table sits at bits [4*i+3:4*i].
  localparam logic [63:0] FWD = 64'h21748FE3DA09B65C;
  localparam logic [63:0] INV = 64'hA970364BD21C8FE5;

  if ((LANES < 1) || (WIDTH % (4 * LN) != 0) || (P < 1)) begin : g_bad
    $fatal(1, "subs_layer_engine: bad WIDTH/LANES");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  work_q, work_d;
  logic              mode_q, mode_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  function automatic logic [3:0] sbox(
    input logic [3:0] n,
    input logic       inv
  );
    logic [5:0] s;
    s = {n, 2'b00};
    return inv ? INV[s +: 4] : FWD[s +: 4];
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      work_q  <= '0;
      mode_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = BUSY;
          work_d  = in_data;
          mode_d  = mode;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        for (int l = 0; l < LN; l++) begin
          int idx;
          idx = int'(cnt_q) * LN + l;
          work_d[idx*4 +: 4] = sbox(work_q[idx*4 +: 4], mode_q);
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == BUSY);
  assign out_valid = (state_q == DONE);
  assign out_data  = work_q;

endmodule

// File: tb/tb_subs_layer_engine.sv
// Directed bench for subs_layer_engine: default, P=4 and P=1 builds.
module tb_subs_layer_engine;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        iv_a = 0, ir_a, md_a = 0, ov_a, or_a = 0, bz_a;
  logic [63:0] id_a = '0, od_a;
  logic        iv_b = 0, ir_b, md_b = 0, ov_b, or_b = 0, bz_b;
  logic [15:0] id_b = '0, od_b;
  logic        iv_c = 0, ir_c, md_c = 0, ov_c, or_c = 0, bz_c;
  logic [63:0] id_c = '0, od_c;

  subs_layer_engine u_a (
    .clk(clk), .reset_n(reset_n),
    .in_valid(iv_a), .in_ready(ir_a), .mode(md_a),
    .in_data(id_a), .out_valid(ov_a), .out_ready(or_a),
    .out_data(od_a), .busy(bz_a)
  );

  subs_layer_engine #(.WIDTH(16), .LANES(1)) u_b (
    .clk(clk), .reset_n(reset_n),
    .in_valid(iv_b), .in_ready(ir_b), .mode(md_b),
    .in_data(id_b), .out_valid(ov_b), .out_ready(or_b),
    .out_data(od_b), .busy(bz_b)
  );

  subs_layer_engine #(.WIDTH(64), .LANES(16)) u_c (
    .clk(clk), .reset_n(reset_n),
    .in_valid(iv_c), .in_ready(ir_c), .mode(md_c),
    .in_data(id_c), .out_valid(ov_c), .out_ready(or_c),
    .out_data(od_c), .busy(bz_c)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_a(input string tag,
                       input logic m,
                       input logic [63:0] d,
                       input logic [63:0] exp,
                       input bit tog,
                       input int hold);
    int n;
    logic [63:0] held;
    chk({tag, "_rdy"}, 64'(ir_a), 64'd1);
    iv_a = 1; md_a = m; id_a = d;
    tick();
    iv_a = 0;
    chk({tag, "_busy"}, 64'(bz_a), 64'd1);
    n = 0;
    while (!ov_a && n < 20) begin
      if (tog) md_a = ~md_a;
      tick();
      n++;
    end
    chk({tag, "_lat"}, 64'(n), 64'd4);
    chk({tag, "_data"}, od_a, exp);
    held = od_a;
    for (int i = 0; i < hold; i++) begin
      iv_a = 1; md_a = ~md_a; id_a = 64'($urandom);
      tick();
      chk({tag, "_hold_ov"}, 64'(ov_a), 64'd1);
      chk({tag, "_hold_od"}, od_a, held);
      chk({tag, "_hold_ir"}, 64'(ir_a), 64'd0);
    end
    iv_a = 0;
    or_a = 1;
    tick();
    or_a = 0;
    chk({tag, "_ir_after"}, 64'(ir_a), 64'd1);
    chk({tag, "_ov_after"}, 64'(ov_a), 64'd0);
  endtask

  initial begin
    int n;
    bit seen;
    #1;
    chk("rst_ir", 64'(ir_a), 64'd1);
    chk("rst_ov", 64'(ov_a), 64'd0);
    chk("rst_bz", 64'(bz_a), 64'd0);
    chk("rst_od", od_a, 64'd0);
    tick();
    reset_n = 1;

    run_a("enc", 1'b0, 64'h0123456789ABCDEF,
          64'hC56B90AD3EF84712, 0, 0);
    run_a("dec", 1'b1, 64'hC56B90AD3EF84712,
          64'h0123456789ABCDEF, 0, 0);
    run_a("dec0", 1'b1, 64'h0,
          64'h5555555555555555, 0, 0);
    run_a("hold", 1'b0, 64'hFEDCBA9876543210,
          64'h21748FE3DA09B65C, 0, 10);
    run_a("tog", 1'b0, 64'h0123456789ABCDEF,
          64'hC56B90AD3EF84712, 1, 0);

    // Reset after two BUSY edges.
    iv_a = 1; md_a = 0; id_a = 64'h0123456789ABCDEF;
    tick();
    iv_a = 0;
    tick();
    tick();
    chk("mid_busy", 64'(bz_a), 64'd1);
    reset_n = 0;
    #1;
    chk("mrst_ir", 64'(ir_a), 64'd1);
    chk("mrst_ov", 64'(ov_a), 64'd0);
    chk("mrst_bz", 64'(bz_a), 64'd0);
    chk("mrst_od", od_a, 64'd0);
    tick();
    tick();
    reset_n = 1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (ov_a) seen = 1;
    end
    chk("mrst_no_ov", 64'(seen), 64'd0);
    run_a("fresh", 1'b0, 64'h0123456789ABCDEF,
          64'hC56B90AD3EF84712, 0, 0);

    // P = 4 build.
    chk("b_rdy", 64'(ir_b), 64'd1);
    iv_b = 1; md_b = 0; id_b = 16'h0000;
    tick();
    iv_b = 0;
    n = 0;
    while (!ov_b && n < 20) begin
      tick();
      n++;
    end
    chk("b_lat", 64'(n), 64'd4);
    chk("b_data", 64'(od_b), 64'h000000000000CCCC);
    or_b = 1;
    tick();
    or_b = 0;
    chk("b_ir_after", 64'(ir_b), 64'd1);

    // P = 1 build.
    chk("c_rdy", 64'(ir_c), 64'd1);
    iv_c = 1; md_c = 0; id_c = 64'hFFFFFFFFFFFFFFFF;
    tick();
    iv_c = 0;
    chk("c_busy", 64'(bz_c), 64'd1);
    n = 0;
    while (!ov_c && n < 20) begin
      tick();
      n++;
    end
    chk("c_lat", 64'(n), 64'd1);
    chk("c_data", od_c, 64'h2222222222222222);
    or_c = 1;
    tick();
    or_c = 0;
    chk("c_ir_after", 64'(ir_c), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
